// File: rtl/mb_spi_status_if.sv
// mb_spi_status_if: bundle of the load/status side and the SPI pins of mb_spi_status.
//   tx_data     frame payload, MSB first (NBITS wide)
//   tx_load     one-cycle strobe capturing tx_data into the hold register
//   busy        frame in progress
//   frame_done  one-cycle pulse at the end of a complete frame
//   abort_err   one-cycle pulse at the end of a short frame
//   frame_count complete frames, modulo 256
//   CLK, CS_N   SPI clock / select from the MCU (asynchronous to clock)
//   MISO        serial data to the MCU
// master: the side driving payload and SPI pins (MCU / bench); slave: the status block.
interface mb_spi_status_if #(
  parameter int unsigned NBITS = 80
);
  logic [NBITS-1:0] tx_data;
  logic             tx_load;
  logic             busy;
  logic             frame_done;
  logic             abort_err;
  logic [7:0]       frame_count;
  logic             CLK;
  logic             CS_N;
  logic             MISO;

  modport master (
    output tx_data, tx_load, CLK, CS_N,
    input  busy, frame_done, abort_err, frame_count, MISO
  );

  modport slave (
    input  tx_data, tx_load, CLK, CS_N,
    output busy, frame_done, abort_err, frame_count, MISO
  );
endinterface

// File: rtl/mb_spi_status.sv
// mb_spi_status: SPI mode-0 slave transmitter that shifts an NBITS status frame to an MCU.
// The MCU pins are oversampled by the system clock; all logic runs on posedge clock.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high
//   bus    mb_spi_status_if.slave: tx_data/tx_load in, busy/frame_done/abort_err/
//          frame_count out, CLK/CS_N in, MISO out
// A frame is complete when at least NBITS CLK rising edges were seen while selected;
// anything shorter ends with an abort_err pulse instead of frame_done.
module mb_spi_status #(
  parameter int unsigned NBITS = 80
) (
  input logic          clock,
  input logic          reset,
  mb_spi_status_if.slave bus
);

  localparam logic [7:0] NBitsW = 8'(NBITS);

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Pin synchronizers: [0] and [1] are the 2-flop synchronizer, [2] is the history flop.
  // CS_N resets to 0 (selected) so a select held low across reset release is not an edge.
  // ---------------------------------------------------------------------------------------------
  logic [2:0] clk_sync_q;
  logic [2:0] cs_sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 3'b000;
      cs_sync_q  <= 3'b000;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], bus.CLK};
      cs_sync_q  <= {cs_sync_q[1:0], bus.CS_N};
    end
  end

  logic clk_rise;
  logic clk_fall;
  logic cs_rise;
  logic cs_fall;

  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall = ~clk_sync_q[1] & clk_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];

  // ---------------------------------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------------------------------
  state_e           state_q;
  logic [NBITS-1:0] hold_q;
  logic [NBITS-1:0] shift_q;
  logic [7:0]       bit_no_q;
  logic [7:0]       frame_count_q;
  logic             miso_q;
  logic             frame_done_q;
  logic             abort_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      shift_q       <= '0;
      bit_no_q      <= 8'd0;
      frame_count_q <= 8'd0;
      miso_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      abort_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      abort_err_q  <= 1'b0;

      // The hold register follows tx_load in every state; in ACTIVE the frame being shifted
      // is untouched, so a new payload goes out with the next frame.
      if (bus.tx_load) begin
        hold_q <= bus.tx_data;
      end

      case (state_q)
        StIdle: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q  <= StActive;
            bit_no_q <= 8'd0;
            // A load coinciding with the select edge bypasses the hold register so the
            // frame carries the freshest data.
            if (bus.tx_load) begin
              shift_q <= bus.tx_data;
              miso_q  <= bus.tx_data[NBITS-1];
            end else begin
              shift_q <= hold_q;
              miso_q  <= hold_q[NBITS-1];
            end
          end
        end

        StActive: begin
          if (cs_rise) begin
            state_q <= StIdle;
            miso_q  <= 1'b0;
            if (bit_no_q >= NBitsW) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
            end else begin
              abort_err_q <= 1'b1;
            end
          end else begin
            // MCU samples on CLK rise: count bits there, saturating.
            if (clk_rise && (bit_no_q != 8'hFF)) begin
              bit_no_q <= bit_no_q + 8'd1;
            end
            // Next bit is presented on CLK fall; zeros are shifted in past the payload.
            if (clk_fall) begin
              shift_q <= {shift_q[NBITS-2:0], 1'b0};
              miso_q  <= shift_q[NBITS-2];
            end
          end
        end

        default: begin
          state_q <= StIdle;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign bus.busy        = (state_q == StActive);
  assign bus.MISO        = miso_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.abort_err   = abort_err_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_mb_spi_status.sv
// Bench for mb_spi_status: directed frames, expected MISO bits and end-of-frame events are
// queued by the stimulus and consumed by independent monitors.
module tb_mb_spi_status;
  localparam int unsigned NB = 80;
  localparam int HALF = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mb_spi_status_if #(.NBITS(NB)) bus ();
  mb_spi_status #(.NBITS(NB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Small-frame instance used for the 256-frame counter wrap.
  mb_spi_status_if #(.NBITS(8)) bus8 ();
  mb_spi_status #(.NBITS(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  typedef struct packed {
    logic       done;
    logic [7:0] count;
  } evt_t;

  logic bit_q[$];
  evt_t evt_q[$];
  int total = 0;
  int bad = 0;
  logic [7:0] exp_count = 8'd0;
  int done8 = 0;
  int abort8 = 0;

  localparam logic [NB-1:0] DataA = 80'hA5A5_0011_2233_4455_6677;
  localparam logic [NB-1:0] DataB = 80'h0123_4567_89AB_CDEF_F00D;
  localparam logic [NB-1:0] DataC = 80'h8000_0000_0000_0000_0001;
  localparam logic [NB-1:0] DataOnes = '1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MISO monitor: the MCU samples on every CLK rising edge.
  always @(posedge bus.CLK) begin
    logic e;
    if (bit_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL miso_unexpected_sample: got CLK rise with no expected bit");
    end else begin
      e = bit_q.pop_front();
      check("miso_bit", 128'(bus.MISO), 128'(e));
    end
  end

  // Event monitor: frame_done / abort_err pulses with frame_count.
  always @(negedge clock) begin
    evt_t e;
    if (!reset) begin
      if (bus.frame_done && bus.abort_err) begin
        total++;
        bad++;
        $display("FAIL done_and_abort: got both 1 expected exclusive");
      end else if (bus.frame_done || bus.abort_err) begin
        if (evt_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got done=%0b abort=%0b expected none",
                   bus.frame_done, bus.abort_err);
        end else begin
          e = evt_q.pop_front();
          check("event_kind_done", 128'(bus.frame_done), 128'(e.done));
          check("event_count", 128'(bus.frame_count), 128'(e.count));
        end
      end
      if (bus8.frame_done) done8++;
      if (bus8.abort_err) abort8++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [NB-1:0] data);
    bus.tx_data = data;
    bus.tx_load = 1'b1;
    cycles(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic frame_start();
    bus.CS_N = 1'b0;
    cycles(HALF);
  endtask

  // CLK pulses for bit positions first .. first+n-1 of data; positions past NB expect 0.
  task automatic pulses(input int first, input int n, input logic [NB-1:0] data);
    for (int i = first; i < first + n; i++) begin
      bit_q.push_back((i < int'(NB)) ? data[NB-1-i] : 1'b0);
      bus.CLK = 1'b1;
      cycles(HALF);
      bus.CLK = 1'b0;
      cycles(HALF);
    end
  endtask

  task automatic frame_end(input logic full);
    evt_t e;
    int n;
    if (full) exp_count = exp_count + 8'd1;
    e.done = full;
    e.count = exp_count;
    evt_q.push_back(e);
    bus.CS_N = 1'b1;
    n = 0;
    while (evt_q.size() != 0 && n < 30) begin
      cycles(1);
      n++;
    end
    check("event_timeout_pending", 128'(evt_q.size()), 128'(0));
    evt_q.delete();
    cycles(HALF);
  endtask

  task automatic frame8();
    bus8.CS_N = 1'b0;
    cycles(4);
    repeat (8) begin
      bus8.CLK = 1'b1;
      cycles(4);
      bus8.CLK = 1'b0;
      cycles(4);
    end
    bus8.CS_N = 1'b1;
    cycles(6);
  endtask

  initial begin
    reset = 1'b1;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    bus.CLK = 1'b0;
    bus.CS_N = 1'b1;
    bus8.tx_data = 8'h5A;
    bus8.tx_load = 1'b0;
    bus8.CLK = 1'b0;
    bus8.CS_N = 1'b1;
    cycles(4);
    check("reset_miso", 128'(bus.MISO), 128'(0));
    check("reset_busy", 128'(bus.busy), 128'(0));
    check("reset_frame_done", 128'(bus.frame_done), 128'(0));
    check("reset_abort_err", 128'(bus.abort_err), 128'(0));
    check("reset_frame_count", 128'(bus.frame_count), 128'(0));
    reset = 1'b0;
    cycles(HALF);
    check("idle_after_reset_busy", 128'(bus.busy), 128'(0));

    // Full frame of A.
    load(DataA);
    frame_start();
    check("busy_in_frame", 128'(bus.busy), 128'(1));
    pulses(0, 80, DataA);
    frame_end(1'b1);
    check("count_after_full", 128'(bus.frame_count), 128'(1));
    check("busy_after_frame", 128'(bus.busy), 128'(0));

    // Short frame of 40 bits, then a frame with no clocks at all.
    frame_start();
    pulses(0, 40, DataA);
    frame_end(1'b0);
    check("miso_after_short", 128'(bus.MISO), 128'(0));
    check("count_after_short", 128'(bus.frame_count), 128'(1));
    frame_start();
    frame_end(1'b0);

    // Load while busy: current frame stays A, the next one is B.
    frame_start();
    pulses(0, 20, DataA);
    load(DataB);
    pulses(20, 60, DataA);
    frame_end(1'b1);
    frame_start();
    pulses(0, 80, DataB);
    frame_end(1'b1);

    // tx_load in the cycle the select edge is detected (third clock edge after the pin).
    bus.CS_N = 1'b0;
    cycles(2);
    bus.tx_data = DataOnes;
    bus.tx_load = 1'b1;
    cycles(1);
    bus.tx_load = 1'b0;
    cycles(HALF - 3);
    check("bypass_first_miso", 128'(bus.MISO), 128'(1));
    pulses(0, 80, DataOnes);
    frame_end(1'b1);

    // Over-clocking: 85 bits, the last five read 0.
    load(DataC);
    frame_start();
    pulses(0, 85, DataC);
    frame_end(1'b1);
    check("count_after_overclock", 128'(bus.frame_count), 128'(5));

    // Reset at bit 30 with CS_N held low.
    load(DataA);
    frame_start();
    pulses(0, 30, DataA);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    exp_count = 8'd0;
    cycles(2 * HALF);
    check("midreset_miso", 128'(bus.MISO), 128'(0));
    check("midreset_busy", 128'(bus.busy), 128'(0));
    check("midreset_count", 128'(bus.frame_count), 128'(0));
    bus.CS_N = 1'b1;
    cycles(HALF);
    load(DataA);
    frame_start();
    check("restart_busy", 128'(bus.busy), 128'(1));
    pulses(0, 80, DataA);
    frame_end(1'b1);
    check("restart_count", 128'(bus.frame_count), 128'(1));

    // Counter wrap on the 8-bit instance.
    repeat (255) frame8();
    check("wrap_count_255", 128'(bus8.frame_count), 128'(255));
    frame8();
    check("wrap_count_256", 128'(bus8.frame_count), 128'(0));
    check("wrap_done_pulses", 128'(done8), 128'(256));
    check("wrap_abort_pulses", 128'(abort8), 128'(0));

    check("leftover_bits", 128'(bit_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mb_spi_status.md
MB_SPI_STATUS -- requirements
Module: mb_spi_status

Interface
REQ-001 SHALL have parameter NBITS, default 80, meaning the frame length in bits shifted to the MCU (legal range 8..254).
REQ-002 SHALL have port clock, in, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset, in, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port tx_data, in, NBITS, the frame payload, transmitted MSB first.
REQ-005 SHALL have port tx_load, in, 1, a one-cycle strobe that captures tx_data into the hold register.
REQ-006 SHALL have port busy, out, 1, high while a frame is in progress (ACTIVE state).
REQ-007 SHALL have port frame_done, out, 1, a one-cycle pulse at the end of a complete frame.
REQ-008 SHALL have port abort_err, out, 1, a one-cycle pulse at the end of a short frame.
REQ-009 SHALL have port frame_count, out, 8, the count of complete frames, wrapping modulo 256.
REQ-010 SHALL have port CLK, in, 1, the SPI clock pin from the MCU (mode 0: idles low, MCU samples on the rising edge).
REQ-011 SHALL have port CS_N, in, 1, the active-low frame select pin from the MCU.
REQ-012 SHALL have port MISO, out, 1, the serial data pin to the MCU.

Function
REQ-013 SHALL pass CLK and CS_N through 2-flop synchronizers plus one history flop each, and detect edges from the last two stages.
REQ-014 SHALL implement two states: IDLE and ACTIVE.
REQ-015 SHALL, on a tx_load strobe in any state, load the hold register with tx_data; the shift register is unaffected while in ACTIVE.
REQ-016 SHALL, on a CS_N falling edge in IDLE, enter ACTIVE, load the shift register from the hold register, and clear bit_no (8-bit) to 0.
REQ-017 SHALL, when tx_load and a CS_N falling edge occur in the same cycle, load the shift register with tx_data directly (bypass) and also update the hold register.
REQ-018 SHALL drive MISO from a register as shift[NBITS-1] in ACTIVE and as 0 in IDLE.
REQ-019 SHALL, in ACTIVE, increment bit_no on each synchronized CLK rising edge, saturating at 255.
REQ-020 SHALL, in ACTIVE, shift the shift register left by one on each synchronized CLK falling edge, filling with 0; MISO therefore reads 0 after NBITS bits.
REQ-021 SHALL update MISO no later than 3 clock cycles after the CLK or CS_N pin transition; correct operation requires the MCU CLK half-period to be at least 4 clock cycles.
REQ-022 SHALL, on a CS_N rising edge in ACTIVE, return to IDLE, and:
- if bit_no >= NBITS: pulse frame_done and increment frame_count;
- otherwise: pulse abort_err and leave frame_count unchanged.
REQ-023 SHALL treat a CS_N rising edge with bit_no == 0 as a short frame (abort_err pulse).
REQ-024 SHALL ignore CLK edges in IDLE and CS_N rising edges in IDLE.
REQ-025 SHALL treat a CS_N falling edge in ACTIVE as impossible: no action is taken.
REQ-026 SHALL assert busy combinationally equal to (state == ACTIVE).
REQ-027 SHALL never assert frame_done and abort_err in the same cycle.

Reset
REQ-028 SHALL, on reset, force state IDLE, MISO 0, busy 0, frame_done 0, abort_err 0, frame_count 0, hold register 0, shift register 0, and bit_no 0.
REQ-029 SHALL reset the CLK synchronizer flops to 0 and the CS_N synchronizer flops to 0 (asserted), so that CS_N held low across reset release starts no frame.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame without pulsing frame_done or abort_err; the next frame starts only at a new CS_N falling edge.

Verification
REQ-031 SHALL cover a full frame: NBITS=80, tx_load with 0xA5A5_0011_2233_4455_6677, CS_N low, 80 CLK pulses (half-period 8 clocks), CS_N high -> MCU-sampled bits equal the payload MSB first; one frame_done pulse; frame_count = 1.
REQ-032 SHALL cover a short frame: CS_N low, 40 CLK pulses, CS_N high -> abort_err pulses once; frame_count unchanged; MISO = 0 afterwards.
REQ-033 SHALL cover load while busy: tx_load of value B during a frame of value A -> the current frame completes as A and the next frame transmits B.
REQ-034 SHALL cover simultaneous events: a tx_load of 0xFF..FF in the same cycle the CS_N falling edge is detected -> the first MISO bit is 1 and the frame carries the new data.
REQ-035 SHALL cover over-clocking and wrap-around: 85 CLK pulses -> bits 81-85 read 0 and frame_done pulses; after 256 complete frames frame_count reads 0.
REQ-036 SHALL cover reset mid-frame: reset at bit 30 with CS_N still low, then released -> no pulses, MISO 0, state IDLE; a later CS_N high-then-low starts a valid frame.
